// File: rtl/hazard_ctrl_unit.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_unit
//
// Hazard controller for the pipelined 64-bit ARM core. It sits beside the
// IF/ID and ID/EX pipeline registers and decides, every cycle, whether the
// front end may advance, whether IF/ID must be squashed and whether a NOP
// bubble is injected into ID/EX.
//
// Two hazard classes are handled:
//   * load-use: an EX-stage load whose destination is read by the ID-stage
//     instruction (any of NUM_SRC operand slots, XZR never matches). The
//     stall is raised in the same cycle, and held LOAD_LAT cycles in total.
//   * taken branch: BR_FLUSH_CYCLES cycles of IF flush followed by exactly
//     one ID/EX bubble cycle.
//
// Ports:
//   clk          in   pipeline clock, rising edge
//   rst          in   asynchronous active-low reset
//   id_src_regs  in   NUM_SRC*REG_W  ID-stage source indices, slot k at [k*REG_W +: REG_W]
//   id_src_valid in   NUM_SRC        slot k operand is really read
//   ex_rd        in   REG_W          EX-stage destination index
//   ex_mem_read  in   1              EX-stage instruction is a load
//   br_taken     in   1              branch resolved taken this cycle
//   if_flush     out  1              squash IF/ID contents
//   bubble_ctrl  out  1              force ID/EX control to NOP
//   IF_ID_write  out  1              IF/ID register enable
//   pc_write     out  1              PC enable
//   hz_state     out  2              registered FSM state (debug)
//
// Optional build macro HAZARD_PERF_CNT_EN adds two saturating CNT_W-bit
// performance counters:
//   stall_cycles out  CNT_W  cycles with pc_write = 0 and if_flush = 0
//   flush_cycles out  CNT_W  cycles with if_flush = 1
// ---------------------------------------------------------------------------
module hazard_ctrl_unit #(
   parameter int REG_W           = 5,
   parameter int NUM_SRC         = 3,
   parameter int ZERO_REG        = 31,
   parameter int BR_FLUSH_CYCLES = 1,
   parameter int LOAD_LAT        = 1,
   parameter int CNT_W           = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_SRC*REG_W-1:0]   id_src_regs,
   input  logic [NUM_SRC-1:0]         id_src_valid,
   input  logic [REG_W-1:0]           ex_rd,
   input  logic                       ex_mem_read,
   input  logic                       br_taken,
   output logic                       if_flush,
   output logic                       bubble_ctrl,
   output logic                       IF_ID_write,
   output logic                       pc_write,
   output logic [1:0]                 hz_state
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]           stall_cycles,
   output logic [CNT_W-1:0]           flush_cycles
`endif
);

   // Out-of-range configurations are rejected at elaboration time.
   if (BR_FLUSH_CYCLES < 1 || BR_FLUSH_CYCLES > 4) begin : gBadFlushCycles
      $error("hazard_ctrl_unit: BR_FLUSH_CYCLES must be in 1..4");
   end
   if (LOAD_LAT < 1 || LOAD_LAT > 3) begin : gBadLoadLat
      $error("hazard_ctrl_unit: LOAD_LAT must be in 1..3");
   end
   if (REG_W < 1 || NUM_SRC < 1 || CNT_W < 1) begin : gBadWidths
      $error("hazard_ctrl_unit: REG_W, NUM_SRC and CNT_W must be positive");
   end

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      BR_FLUSH  = 2'd1,
      BR_BUBBLE = 2'd2,
      LD_STALL  = 2'd3
   } hzState_t;

   localparam logic [REG_W-1:0] ZeroIdx   = REG_W'(ZERO_REG);
   localparam logic [1:0]       FlushInit = 2'(BR_FLUSH_CYCLES - 1);
   localparam logic [1:0]       LdInit    = 2'(LOAD_LAT - 1);

   hzState_t   state_q, state_d;
   logic [1:0] flushCnt_q, flushCnt_d;
   logic [1:0] ldCnt_q, ldCnt_d;
   logic       loadHit;

   // Load-use detection: an EX load to a real register (not XZR) that some
   // genuinely-read ID operand slot depends on.
   always_comb begin
      loadHit = 1'b0;
      if (ex_mem_read && (ex_rd != ZeroIdx)) begin
         for (int k = 0; k < NUM_SRC; k++) begin
            if (id_src_valid[k] && (id_src_regs[k*REG_W +: REG_W] == ex_rd)) begin
               loadHit = 1'b1;
            end
         end
      end
   end

   // Next-state and output decode. The first cycle of a load-use stall is
   // raised combinationally from RUN so the dependent instruction never
   // advances; a taken branch out-prioritises entering LD_STALL because the
   // stalled instruction is on the wrong path anyway. While reset is held the
   // outputs are forced to their free-running values without waiting for a
   // clock edge.
   always_comb begin
      state_d     = state_q;
      flushCnt_d  = flushCnt_q;
      ldCnt_d     = ldCnt_q;
      if_flush    = 1'b0;
      bubble_ctrl = 1'b0;
      IF_ID_write = 1'b1;
      pc_write    = 1'b1;

      case (state_q)
         RUN: begin
            if (loadHit) begin
               bubble_ctrl = 1'b1;
               IF_ID_write = 1'b0;
               pc_write    = 1'b0;
            end
            if (br_taken) begin
               state_d    = BR_FLUSH;
               flushCnt_d = FlushInit;
            end else if (loadHit && (LOAD_LAT > 1)) begin
               state_d = LD_STALL;
               ldCnt_d = LdInit;
            end
         end
         BR_FLUSH: begin
            if_flush    = 1'b1;
            IF_ID_write = 1'b0;
            pc_write    = 1'b0;
            if (flushCnt_q != 2'd0) begin
               flushCnt_d = flushCnt_q - 2'd1;
            end else begin
               state_d = BR_BUBBLE;
            end
         end
         BR_BUBBLE: begin
            bubble_ctrl = 1'b1;
            if (br_taken) begin
               state_d    = BR_FLUSH;
               flushCnt_d = FlushInit;
            end else begin
               state_d = RUN;
            end
         end
         LD_STALL: begin
            bubble_ctrl = 1'b1;
            IF_ID_write = 1'b0;
            pc_write    = 1'b0;
            if (br_taken) begin
               state_d    = BR_FLUSH;
               flushCnt_d = FlushInit;
               ldCnt_d    = 2'd0;
            end else if (ldCnt_q > 2'd1) begin
               ldCnt_d = ldCnt_q - 2'd1;
            end else begin
               state_d = RUN;
               ldCnt_d = 2'd0;
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase

      if (!rst) begin
         if_flush    = 1'b0;
         bubble_ctrl = 1'b0;
         IF_ID_write = 1'b1;
         pc_write    = 1'b1;
      end
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= RUN;
         flushCnt_q <= 2'd0;
         ldCnt_q    <= 2'd0;
      end else begin
         state_q    <= state_d;
         flushCnt_q <= flushCnt_d;
         ldCnt_q    <= ldCnt_d;
      end
   end

   assign hz_state = state_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stallCnt_q;
   logic [CNT_W-1:0] flushCnt2_q;

   // Saturating performance counters; they stick at all-ones so a long run
   // never wraps back to a misleadingly small number.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stallCnt_q  <= '0;
         flushCnt2_q <= '0;
      end else begin
         if (!pc_write && !if_flush && (stallCnt_q != {CNT_W{1'b1}})) begin
            stallCnt_q <= stallCnt_q + CNT_W'(1);
         end
         if (if_flush && (flushCnt2_q != {CNT_W{1'b1}})) begin
            flushCnt2_q <= flushCnt2_q + CNT_W'(1);
         end
      end
   end

   assign stall_cycles = stallCnt_q;
   assign flush_cycles = flushCnt2_q;
`else
   // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl_unit
//
// Drives two hazard_ctrl_unit instances from the same inputs: dutA with the
// default timing (1 flush cycle, 1 load stall cycle) and dutB with 3 flush
// cycles, 3 load stall cycles and 4-bit perf counters. Expected outputs come
// from a cycle-count model: how many flush cycles remain, whether a bubble
// cycle is due, and how many stall cycles remain.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl_unit;

   logic        clk;
   logic        rst;
   logic [14:0] id_src_regs;
   logic [2:0]  id_src_valid;
   logic [4:0]  ex_rd;
   logic        ex_mem_read;
   logic        br_taken;

   logic       ifFlushA, bubbleA, ifIdWriteA, pcWriteA;
   logic [1:0] hzA;
   logic       ifFlushB, bubbleB, ifIdWriteB, pcWriteB;
   logic [1:0] hzB;
   logic [5:0] obsA, obsB;

`ifdef HAZARD_PERF_CNT_EN
   logic [15:0] stallCycA, flushCycA;
   logic [3:0]  stallCycB, flushCycB;
`endif

   assign obsA = {ifFlushA, bubbleA, ifIdWriteA, pcWriteA, hzA};
   assign obsB = {ifFlushB, bubbleB, ifIdWriteB, pcWriteB, hzB};

   int total;
   int bad;

   // Model state per instance (0 = dutA, 1 = dutB).
   int flushLeft[2];
   int stallLeft[2];
   bit bubbleNow[2];
   int perfStall[2];
   int perfFlush[2];
   int flushCfg[2];
   int ldCfg[2];
   int satMax[2];

   hazard_ctrl_unit #(
      .REG_W(5), .NUM_SRC(3), .ZERO_REG(31),
      .BR_FLUSH_CYCLES(1), .LOAD_LAT(1), .CNT_W(16)
   ) dutA (
      .clk(clk), .rst(rst),
      .id_src_regs(id_src_regs), .id_src_valid(id_src_valid),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .br_taken(br_taken),
      .if_flush(ifFlushA), .bubble_ctrl(bubbleA), .IF_ID_write(ifIdWriteA),
      .pc_write(pcWriteA), .hz_state(hzA)
`ifdef HAZARD_PERF_CNT_EN
      , .stall_cycles(stallCycA), .flush_cycles(flushCycA)
`endif
   );

   hazard_ctrl_unit #(
      .REG_W(5), .NUM_SRC(3), .ZERO_REG(31),
      .BR_FLUSH_CYCLES(3), .LOAD_LAT(3), .CNT_W(4)
   ) dutB (
      .clk(clk), .rst(rst),
      .id_src_regs(id_src_regs), .id_src_valid(id_src_valid),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .br_taken(br_taken),
      .if_flush(ifFlushB), .bubble_ctrl(bubbleB), .IF_ID_write(ifIdWriteB),
      .pc_write(pcWriteB), .hz_state(hzB)
`ifdef HAZARD_PERF_CNT_EN
      , .stall_cycles(stallCycB), .flush_cycles(flushCycB)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A load-use hazard exists when a real (non-XZR) load destination is read
   // by any valid operand slot.
   function automatic bit loadHit();
      logic [4:0] slot;
      if (ex_mem_read !== 1'b1 || ex_rd == 5'd31) return 1'b0;
      for (int k = 0; k < 3; k++) begin
         slot = id_src_regs[k*5 +: 5];
         if (id_src_valid[k] && slot == ex_rd) return 1'b1;
      end
      return 1'b0;
   endfunction

   // Expected {if_flush, bubble_ctrl, IF_ID_write, pc_write, hz_state}.
   function automatic logic [5:0] expOut(int i);
      if (rst !== 1'b1)        return 6'b001100;
      if (flushLeft[i] > 0)    return 6'b100001;
      if (bubbleNow[i])        return 6'b011110;
      if (stallLeft[i] > 0)    return 6'b010011;
      if (loadHit())           return 6'b010000;
      return 6'b001100;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 2; i++) begin
         flushLeft[i] = 0;
         stallLeft[i] = 0;
         bubbleNow[i] = 1'b0;
         perfStall[i] = 0;
         perfFlush[i] = 0;
      end
   endtask

   // Advance the model by one clock using the inputs present at the edge.
   task automatic modelClock();
      logic [5:0] e;
      bit hit;
      if (rst !== 1'b1) begin
         modelReset();
         return;
      end
      hit = loadHit();
      for (int i = 0; i < 2; i++) begin
         e = expOut(i);
         if (e[5]) begin
            if (perfFlush[i] < satMax[i]) perfFlush[i]++;
         end else if (!e[2]) begin
            if (perfStall[i] < satMax[i]) perfStall[i]++;
         end
         if (flushLeft[i] > 0) begin
            flushLeft[i]--;
            if (flushLeft[i] == 0) bubbleNow[i] = 1'b1;
         end else if (bubbleNow[i]) begin
            bubbleNow[i] = 1'b0;
            if (br_taken) flushLeft[i] = flushCfg[i];
         end else if (stallLeft[i] > 0) begin
            if (br_taken) begin
               stallLeft[i] = 0;
               flushLeft[i] = flushCfg[i];
            end else begin
               stallLeft[i]--;
            end
         end else begin
            if (br_taken) flushLeft[i] = flushCfg[i];
            else if (hit && ldCfg[i] > 1) stallLeft[i] = ldCfg[i] - 1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      modelClock();
      #1;
   endtask

   task automatic applyStimulus(input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                                input logic [2:0] v, input logic [4:0] rd,
                                input logic mr, input logic br);
      id_src_regs  = {r2, r1, r0};
      id_src_valid = v;
      ex_rd        = rd;
      ex_mem_read  = mr;
      br_taken     = br;
   endtask

   task automatic setIdle();
      applyStimulus(5'd1, 5'd2, 5'd3, 3'b000, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic drain(input int n);
      setIdle();
      for (int c = 0; c < n; c++) tick();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      applyStimulus(5'd5, 5'd5, 5'd5, 3'b111, 5'd5, 1'b1, 1'b1);
      modelReset();
      #2;
      total++;
      if (obsA !== 6'b001100) begin
         bad++;
         $display("[TB] FAIL reset.outA got=%b want=%b", obsA, 6'b001100);
      end
      total++;
      if (obsB !== 6'b001100) begin
         bad++;
         $display("[TB] FAIL reset.outB got=%b want=%b", obsB, 6'b001100);
      end
      setIdle();
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      drain(2);
   endtask

   task automatic test_load_use();
      drain(6);
      applyStimulus(5'd1, 5'd5, 5'd2, 3'b010, 5'd5, 1'b1, 1'b0);
      @(negedge clk);
      total++;
      if (obsA !== 6'b010000) begin
         bad++;
         $display("[TB] FAIL loadUse.stallA got=%b want=%b", obsA, 6'b010000);
      end
      total++;
      if (obsB !== expOut(1)) begin
         bad++;
         $display("[TB] FAIL loadUse.stallB got=%b want=%b", obsB, expOut(1));
      end
      tick();
      setIdle();
      @(negedge clk);
      total++;
      if (obsA !== 6'b001100) begin
         bad++;
         $display("[TB] FAIL loadUse.releaseA got=%b want=%b", obsA, 6'b001100);
      end
      total++;
      if (obsB !== expOut(1)) begin
         bad++;
         $display("[TB] FAIL loadUse.followB got=%b want=%b", obsB, expOut(1));
      end
      drain(4);
   endtask

   task automatic test_masking();
      drain(6);
      applyStimulus(5'd31, 5'd1, 5'd2, 3'b001, 5'd31, 1'b1, 1'b0);
      @(negedge clk);
      total++;
      if (obsA !== 6'b001100 || obsB !== 6'b001100) begin
         bad++;
         $display("[TB] FAIL mask.xzr got=%b/%b want=%b", obsA, obsB, 6'b001100);
      end
      tick();
      applyStimulus(5'd1, 5'd2, 5'd7, 3'b011, 5'd7, 1'b1, 1'b0);
      @(negedge clk);
      total++;
      if (obsA !== 6'b001100 || obsB !== 6'b001100) begin
         bad++;
         $display("[TB] FAIL mask.invalidSlot got=%b/%b want=%b", obsA, obsB, 6'b001100);
      end
      tick();
      // Same slot made valid: now it must stall.
      applyStimulus(5'd1, 5'd2, 5'd7, 3'b100, 5'd7, 1'b1, 1'b0);
      @(negedge clk);
      total++;
      if (obsA !== 6'b010000) begin
         bad++;
         $display("[TB] FAIL mask.validSlot got=%b want=%b", obsA, 6'b010000);
      end
      tick();
      drain(4);
   endtask

   task automatic test_branch();
      int seqA[6];
      int seqB[6];
      seqA = '{0, 1, 2, 0, 0, 0};
      seqB = '{0, 1, 1, 1, 2, 0};
      drain(6);
      applyStimulus(5'd1, 5'd2, 5'd3, 3'b000, 5'd0, 1'b0, 1'b1);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         total++;
         if (hzA !== 2'(seqA[c]) || hzB !== 2'(seqB[c])) begin
            bad++;
            $display("[TB] FAIL branch.hz c=%0d got=%0d/%0d want=%0d/%0d", c, hzA, hzB, seqA[c], seqB[c]);
         end
         total++;
         if (obsA !== expOut(0) || obsB !== expOut(1)) begin
            bad++;
            $display("[TB] FAIL branch.out c=%0d got=%b/%b want=%b/%b", c, obsA, obsB, expOut(0), expOut(1));
         end
         tick();
         setIdle();
      end
   endtask

   task automatic test_load_lat();
      logic [3:0] pcSeq;
      pcSeq = 4'b1000;
      drain(6);
      applyStimulus(5'd9, 5'd4, 5'd0, 3'b011, 5'd9, 1'b1, 1'b0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         total++;
         if (pcWriteB !== pcSeq[c] || obsB !== expOut(1) || obsA !== expOut(0)) begin
            bad++;
            $display("[TB] FAIL loadLat.c%0d got=%b/%b want=%b/%b", c, obsA, obsB, expOut(0), expOut(1));
         end
         tick();
         setIdle();
      end
      // Branch during the stall aborts it.
      drain(4);
      applyStimulus(5'd9, 5'd4, 5'd0, 3'b011, 5'd9, 1'b1, 1'b0);
      tick();
      applyStimulus(5'd1, 5'd2, 5'd3, 3'b000, 5'd0, 1'b0, 1'b1);
      @(negedge clk);
      total++;
      if (hzB !== 2'd3) begin
         bad++;
         $display("[TB] FAIL loadLat.inStall got=%0d want=3", hzB);
      end
      tick();
      setIdle();
      @(negedge clk);
      total++;
      if (hzB !== 2'd1 || obsB !== expOut(1)) begin
         bad++;
         $display("[TB] FAIL loadLat.abort got=%b want=%b", obsB, expOut(1));
      end
      drain(8);
   endtask

   task automatic test_simultaneous();
      int seqB[6];
      seqB = '{0, 1, 1, 1, 2, 1};
      drain(6);
      for (int c = 0; c < 6; c++) begin
         if (c == 0) applyStimulus(5'd6, 5'd6, 5'd6, 3'b001, 5'd6, 1'b1, 1'b1);
         else if (c == 4) applyStimulus(5'd1, 5'd2, 5'd3, 3'b000, 5'd0, 1'b0, 1'b1);
         else setIdle();
         @(negedge clk);
         total++;
         if (hzB !== 2'(seqB[c]) || obsB !== expOut(1) || obsA !== expOut(0)) begin
            bad++;
            $display("[TB] FAIL simul.c%0d got=%b/%b want=%b/%b hzB_want=%0d", c, obsA, obsB, expOut(0), expOut(1), seqB[c]);
         end
         tick();
      end
      drain(8);
   endtask

   task automatic test_async_reset();
      drain(6);
      applyStimulus(5'd1, 5'd2, 5'd3, 3'b000, 5'd0, 1'b0, 1'b1);
      tick();
      applyStimulus(5'd5, 5'd5, 5'd5, 3'b111, 5'd5, 1'b1, 1'b0);
      #1;
      total++;
      if (hzB !== 2'd1) begin
         bad++;
         $display("[TB] FAIL asyncReset.preFlush got=%0d want=1", hzB);
      end
      #1;
      rst = 1'b0;
      #1;
      total++;
      if (obsA !== 6'b001100 || obsB !== 6'b001100) begin
         bad++;
         $display("[TB] FAIL asyncReset.immediate got=%b/%b want=%b", obsA, obsB, 6'b001100);
      end
      modelReset();
      tick();
      setIdle();
      @(negedge clk);
      total++;
      if (obsB !== 6'b001100) begin
         bad++;
         $display("[TB] FAIL asyncReset.held got=%b want=%b", obsB, 6'b001100);
      end
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
   endtask

`ifdef HAZARD_PERF_CNT_EN
   task automatic test_perf();
      applyStimulus(5'd8, 5'd0, 5'd0, 3'b001, 5'd8, 1'b1, 1'b0);
      for (int c = 0; c < 20; c++) tick();
      setIdle();
      @(negedge clk);
      total++;
      if (stallCycB !== 4'd15) begin
         bad++;
         $display("[TB] FAIL perf.stallSat got=%0d want=15", stallCycB);
      end
      total++;
      if (stallCycA !== 16'(perfStall[0]) || flushCycB !== 4'(perfFlush[1])) begin
         bad++;
         $display("[TB] FAIL perf.model got=%0d/%0d want=%0d/%0d", stallCycA, flushCycB, perfStall[0], perfFlush[1]);
      end
   endtask
`endif

   task automatic test_random();
      logic [4:0] pool[5];
      pool = '{5'd0, 5'd3, 5'd5, 5'd7, 5'd31};
      for (int c = 0; c < 400; c++) begin
         applyStimulus(pool[$urandom_range(0, 4)], pool[$urandom_range(0, 4)], pool[$urandom_range(0, 4)],
                       3'($urandom_range(0, 7)), pool[$urandom_range(0, 4)],
                       1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));
         @(negedge clk);
         total++;
         if (obsA !== expOut(0)) begin
            bad++;
            $display("[TB] FAIL random.A c=%0d got=%b want=%b", c, obsA, expOut(0));
         end
         total++;
         if (obsB !== expOut(1)) begin
            bad++;
            $display("[TB] FAIL random.B c=%0d got=%b want=%b", c, obsB, expOut(1));
         end
`ifdef HAZARD_PERF_CNT_EN
         total++;
         if (stallCycB !== 4'(perfStall[1]) || flushCycB !== 4'(perfFlush[1])) begin
            bad++;
            $display("[TB] FAIL random.perfB c=%0d got=%0d/%0d want=%0d/%0d", c, stallCycB, flushCycB, perfStall[1], perfFlush[1]);
         end
`endif
         tick();
      end
      setIdle();
   endtask

   // Test sequence.
   initial begin
      total = 0;
      bad   = 0;
      flushCfg = '{1, 3};
      ldCfg    = '{1, 3};
      satMax   = '{65535, 15};
      modelReset();
      test_reset();
      test_load_use();
      test_masking();
      test_branch();
      test_load_lat();
      test_simultaneous();
      test_async_reset();
`ifdef HAZARD_PERF_CNT_EN
      test_perf();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
